// File: rtl/axi4_lite_master.sv
// AXI4-Lite initiator: turns single-beat user read/write commands into
// AXI4-Lite transactions. The write path (AW/W/B) and the read path (AR/R)
// are independent FSMs, each allowing one outstanding transaction.
// Every output comes straight from a flop, so no input reaches an output
// combinationally.
module axi4_lite_master #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 32
) (
   input  logic                      ACLK,
   input  logic                      ARESET,
   // user write command
   input  logic                      cmd_write,
   input  logic [ADDRESS_WIDTH-1:0]  cmd_waddr,
   input  logic [DATA_WIDTH-1:0]     cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
   // user read command
   input  logic                      cmd_read,
   input  logic [ADDRESS_WIDTH-1:0]  cmd_raddr,
   // user status
   output logic                      write_busy,
   output logic                      write_done,
   output logic [1:0]                write_resp,
   output logic                      read_busy,
   output logic                      read_done,
   output logic [DATA_WIDTH-1:0]     read_data,
   output logic [1:0]                read_resp,
   // write address channel
   output logic [ADDRESS_WIDTH-1:0]  AWADDR,
   output logic                      AWVALID,
   input  logic                      AWREADY,
   // write data channel
   output logic [DATA_WIDTH-1:0]     WDATA,
   output logic [DATA_WIDTH/8-1:0]   WSTRB,
   output logic                      WVALID,
   input  logic                      WREADY,
   // write response channel
   input  logic [1:0]                BRESP,
   input  logic                      BVALID,
   output logic                      BREADY,
   // read address channel
   output logic [ADDRESS_WIDTH-1:0]  ARADDR,
   output logic                      ARVALID,
   input  logic                      ARREADY,
   // read data channel
   input  logic [DATA_WIDTH-1:0]     RDATA,
   input  logic [1:0]                RRESP,
   input  logic                      RVALID,
   output logic                      RREADY
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   localparam logic [1:0] W_IDLE = 2'd0;
   localparam logic [1:0] W_SEND = 2'd1;
   localparam logic [1:0] W_RESP = 2'd2;

   localparam logic [1:0] R_IDLE = 2'd0;
   localparam logic [1:0] R_ADDR = 2'd1;
   localparam logic [1:0] R_DATA = 2'd2;

   logic [1:0] w_state;
   logic [1:0] r_state;
   logic       aw_sent;
   logic       w_sent;

   // An AW or W beat counts as delivered if it went out earlier or is
   // handshaking on this very edge; both must be true to move on to B.
   logic aw_done_now;
   logic w_done_now;
   assign aw_done_now = aw_sent | (AWVALID & AWREADY);
   assign w_done_now  = w_sent  | (WVALID  & WREADY);

   // Write path: capture command, drive AW and W independently, then await B.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         // NOTE: every register, payloads included, is cleared on reset so the
         // bus shows all-zero outputs; a transaction in flight is dropped silently.
         w_state    <= W_IDLE;
         aw_sent    <= 1'b0;
         w_sent     <= 1'b0;
         AWADDR     <= '0;
         AWVALID    <= 1'b0;
         WDATA      <= '0;
         WSTRB      <= '0;
         WVALID     <= 1'b0;
         BREADY     <= 1'b0;
         write_busy <= 1'b0;
         write_done <= 1'b0;
         write_resp <= 2'b00;
      end else begin
         // NOTE: non-blocking assignments throughout, so every decision in this
         // block sees the pre-edge register values regardless of statement order.
         write_done <= 1'b0;
         case (w_state)
            W_IDLE: begin
               if (cmd_write) begin
                  AWADDR     <= cmd_waddr;
                  WDATA      <= cmd_wdata;
                  WSTRB      <= cmd_wstrb[STRB_WIDTH-1:0];
                  AWVALID    <= 1'b1;
                  WVALID     <= 1'b1;
                  aw_sent    <= 1'b0;
                  w_sent     <= 1'b0;
                  write_busy <= 1'b1;
                  w_state    <= W_SEND;
               end
            end
            W_SEND: begin
               if (AWVALID && AWREADY) begin
                  AWVALID <= 1'b0;
                  aw_sent <= 1'b1;
               end
               if (WVALID && WREADY) begin
                  WVALID <= 1'b0;
                  w_sent <= 1'b1;
               end
               if (aw_done_now && w_done_now) begin
                  BREADY  <= 1'b1;
                  w_state <= W_RESP;
               end
            end
            W_RESP: begin
               if (BVALID && BREADY) begin
                  write_resp <= BRESP;
                  write_done <= 1'b1;
                  BREADY     <= 1'b0;
                  write_busy <= 1'b0;
                  w_state    <= W_IDLE;
               end
            end
            // NOTE: the unused encoding falls back to idle rather than sticking.
            default: w_state <= W_IDLE;
         endcase
      end
   end

   // Read path: capture command, drive AR until accepted, then await R.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_state   <= R_IDLE;
         ARADDR    <= '0;
         ARVALID   <= 1'b0;
         RREADY    <= 1'b0;
         read_busy <= 1'b0;
         read_done <= 1'b0;
         read_data <= '0;
         read_resp <= 2'b00;
      end else begin
         read_done <= 1'b0;
         case (r_state)
            R_IDLE: begin
               if (cmd_read) begin
                  ARADDR    <= cmd_raddr;
                  ARVALID   <= 1'b1;
                  read_busy <= 1'b1;
                  r_state   <= R_ADDR;
               end
            end
            R_ADDR: begin
               if (ARVALID && ARREADY) begin
                  ARVALID <= 1'b0;
                  RREADY  <= 1'b1;
                  r_state <= R_DATA;
               end
            end
            R_DATA: begin
               if (RVALID && RREADY) begin
                  read_data <= RDATA;
                  read_resp <= RRESP;
                  read_done <= 1'b1;
                  RREADY    <= 1'b0;
                  read_busy <= 1'b0;
                  r_state   <= R_IDLE;
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

endmodule

// File: doc/axi4_lite_master.md
Name: axi4_lite_master

Overview:
AXI4-Lite initiator that converts single-beat user-side read and write commands into AXI4-Lite transactions toward a slave such as axi4_lite_slave. The write path (AW/W/B) and read path (AR/R) are independent and may be in flight at the same time. There is one outstanding transaction per direction. It sits between a CPU or DMA-style command source and the AXI-Lite fabric.

Parameters:
DATA_WIDTH, 32, data bus width in bits (multiple of 8)
ADDRESS_WIDTH, 32, address bus width in bits

Ports:
ACLK  input  1  clock; all logic on rising edge
ARESET  input  1  synchronous reset, active-high
cmd_write  input  1  write request; sampled only when write_busy=0
cmd_waddr  input  ADDRESS_WIDTH  write address, captured with cmd_write
cmd_wdata  input  DATA_WIDTH  write data, captured with cmd_write
cmd_wstrb  input  DATA_WIDTH/8  byte strobes, captured with cmd_write
cmd_read  input  1  read request; sampled only when read_busy=0
cmd_raddr  input  ADDRESS_WIDTH  read address, captured with cmd_read
write_busy  output  1  write transaction in progress
write_done  output  1  one-cycle pulse: B response received
write_resp  output  2  BRESP of the last write, valid with write_done and held after
read_busy  output  1  read transaction in progress
read_done  output  1  one-cycle pulse: R data received
read_data  output  DATA_WIDTH  RDATA of the last read, held until the next read completes
read_resp  output  2  RRESP of the last read, held
AWADDR/AWVALID  output  ADDRESS_WIDTH/1  write address channel
AWREADY  input  1
WDATA/WSTRB/WVALID  output  DATA_WIDTH/DATA_WIDTH/8/1  write data channel
WREADY  input  1
BRESP/BVALID  input  2/1  write response channel
BREADY  output  1
ARADDR/ARVALID  output  ADDRESS_WIDTH/1  read address channel
ARREADY  input  1
RDATA/RRESP/RVALID  input  DATA_WIDTH/2/1  read data channel
RREADY  output  1

Behaviour:
- Reset (ARESET=1 at a rising edge):
  - All outputs go to 0: VALIDs, READYs, busy, done, resp, read_data, AW/W/AR payloads.
  - Both FSMs go to IDLE.
  - Reset mid-transaction abandons the transaction without a done pulse. Slave recovery is the system's responsibility.
- All outputs are registered. No combinational path from any input to any output.
- Write FSM states: W_IDLE, W_SEND, W_RESP.
  - W_IDLE: if cmd_write=1 at edge N, capture addr/data/strb. At N+1: AWVALID=1, WVALID=1, write_busy=1, state W_SEND.
  - W_SEND: AW and W handshake independently.
    - AWVALID drops the cycle after AWVALID&&AWREADY.
    - WVALID drops the cycle after WVALID&&WREADY.
    - Either order or the same cycle is legal.
    - Payloads stay stable while the corresponding VALID=1.
    - When both handshakes are complete (tracked by aw_sent/w_sent flags), go to W_RESP with BREADY=1.
    - If the last handshake occurs at edge M, BREADY=1 from M+1.
  - W_RESP: on BVALID&&BREADY at edge K: write_resp<=BRESP; write_done=1 for exactly cycle K+1; BREADY=0, write_busy=0, state W_IDLE at K+1.
  - A new cmd_write is accepted no earlier than edge K+1. Back-to-back throughput: done at K+1, new AWVALID at K+2.
- Read FSM states: R_IDLE, R_ADDR, R_DATA.
  - R_IDLE: cmd_read at edge N captures the address. At N+1: ARVALID=1, read_busy=1, state R_ADDR.
  - R_ADDR: on ARVALID&&ARREADY, ARVALID<=0, RREADY<=1, state R_DATA.
  - R_DATA: on RVALID&&RREADY at edge K: read_data<=RDATA, read_resp<=RRESP; read_done pulses at K+1; RREADY=0, read_busy=0, state R_IDLE.
- VALID is never deasserted before its handshake, per the AXI rule.
- VALID never depends on the corresponding READY.
- cmd_write or cmd_read while the respective busy=1 is ignored: not queued, no side effects.
- Read and write paths are fully independent. Simultaneous cmd_write and cmd_read are both accepted. No ordering is enforced between them.
- BVALID or RVALID arriving while not in W_RESP or R_DATA is not acknowledged (READY=0) and is left pending.

Test Plan:
- Write 0x0000_0010 <= 0xDEAD_BEEF, wstrb 0xF; slave gives AWREADY and WREADY together, BVALID 2 cycles later with BRESP=0 -> AW/W payload correct, write_done single pulse, write_resp=0, busy low after the pulse.
- Write with WREADY 3 cycles before AWREADY, then repeat with AWREADY first -> each VALID drops independently after its own handshake, BREADY rises only after both, exactly one write_done per write.
- Read 0x0000_0020; slave ARREADY after 4 cycles, RDATA=0x1234_5678, RRESP=2'b10 -> ARVALID held stable until the handshake, read_data=0x1234_5678, read_resp=2, read_done one pulse.
- cmd_write and cmd_read in the same cycle, with RVALID and BVALID also in the same cycle -> both complete, both done pulses in the same cycle, data and resp correct.
- cmd_write pulsed again while write_busy=1 with a different address -> ignored; only the first address appears on AWADDR.
- ARESET asserted while in W_SEND with AWVALID=1 and WVALID=1 -> the next cycle all outputs are 0, no write_done; a new command after reset completes normally.
